// File: rtl/add_sub_pkg.sv
// Shared constants for the sequential adder/subtractor: default widths, slice count, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package add_sub_pkg;

    localparam int ADDSUB_WIDTH = 32;
    localparam int ADDSUB_SLICE = 4;
    localparam int NSLICE       = ADDSUB_WIDTH / ADDSUB_SLICE;
    localparam int CNT_W        = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // FSM encoding, kept as plain constants so older tools and netlists see fixed codes
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/addsub_slice.sv
// SLICE-bit ripple-carry adder; also exposes the carry into its MSB for signed-overflow detection.
// Latency: combinational.
// Backpressure: none (pure datapath).
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [SLICE:0] c;

    // Ripple the carry bit by bit across the slice
    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]  = a[i] ^ b[i] ^ c[i];
            c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout     = c[SLICE];
    assign c_msb_in = c[SLICE-1];

endmodule

// File: rtl/add_sub_seq_32.sv
// Sequential add/sub: one SLICE-bit chunk per cycle, LSB first; ovf/zero only with ADDSUB_FLAGS_EN.
// Latency: WIDTH/SLICE cycles from accept edge to out_valid; one op per WIDTH/SLICE+2 cycles.
// Backpressure: result and flags held while out_valid && !out_ready; no new op accepted until IDLE.
module add_sub_seq_32
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH,
    parameter int SLICE = ADDSUB_SLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    logic [1:0]           state;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     a_sr;
    logic [WIDTH-1:0]     b_sr;
    logic                 carry;
    logic [WIDTH-SLICE-1:0] res;

    logic [SLICE-1:0]     slice_sum;
    logic                 slice_cout;
    logic                 slice_c_msb;
    logic [WIDTH-1:0]     next_full;
    logic                 last_slice;

    logic [WIDTH-1:0]     s_q;
    logic                 cout_q;

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a        (a_sr[SLICE-1:0]),
        .b        (b_sr[SLICE-1:0]),
        .cin      (carry),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_c_msb)
    );

    // New slice enters at the top; after the last slice this is the complete result
    assign next_full  = {slice_sum, res};
    assign last_slice = (state == ST_RUN) && (cnt == LAST);

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign s         = s_q;
    assign cout      = cout_q;

    // Control FSM plus operand/result shift registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            res   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        state <= ST_RUN;
                        a_sr  <= x;
                        // Subtract as x + ~y + 1: invert B and seed the carry with 1
                        b_sr  <= y ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        res   <= '0;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> SLICE;
                    b_sr  <= b_sr >> SLICE;
                    carry <= slice_cout;
                    res   <= next_full[WIDTH-1:SLICE];
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Result and carry are captured only on the final slice so they hold until the next DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else if (last_slice) begin
            s_q    <= next_full;
            cout_q <= slice_cout;
        end
    end

`ifdef ADDSUB_FLAGS_EN
    logic ovf_q;
    logic zero_q;

    // Signed overflow is carry-in vs carry-out of the top bit; zero is checked on the full result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (last_slice) begin
            ovf_q  <= slice_c_msb ^ slice_cout;
            zero_q <= (next_full == '0);
        end
    end

    assign ovf  = ovf_q;
    assign zero = zero_q;
`else
    // Flags compiled out: ports stay for a common footprint but are constant
    logic unused_msb;
    assign unused_msb = slice_c_msb;
    assign ovf        = 1'b0;
    assign zero       = 1'b0;
`endif

endmodule

// File: tb/tb_add_sub_seq_32.sv
module tb_add_sub_seq_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sub;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    add_sub_seq_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operands
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [32:0] wide;
        logic [31:0] r;
        logic        c;
        logic        o;
        logic        z;
        longint      sa;
        longint      sb;
        longint      sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op) begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            r    = wide[31:0];
            c    = wide[32];
            sr   = sa + sb;
        end
        o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        z = (r == 32'd0);
`ifndef ADDSUB_FLAGS_EN
        o = 1'b0;
        z = 1'b0;
`endif
        return {z, o, c, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, wait for the result, check it and its latency, then complete the handshake
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic op);
        logic [34:0] e;
        int lat;
        int w;
        e = model(a, b, op);
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1; w++;
        end
        x = a; y = b; sub = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        check({tag, "_lat"},  64'(lat),  64'd8);
        check({tag, "_s"},    64'(s),    64'(e[31:0]));
        check({tag, "_cout"}, 64'(cout), 64'(e[32]));
        check({tag, "_ovf"},  64'(ovf),  64'(e[33]));
        check({tag, "_zero"}, 64'(zero), 64'(e[34]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_rdy"},  64'(in_ready),  64'd1);
        check({tag, "_ovld"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [34:0] e;
        logic [31:0] rq_s[$];
        logic        rq_c[$];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rop;
        int          w;
        int          issued;
        int          got;
        int          cyc;
        int          last;

        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; x = '0; y = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_s",         64'(s),         64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(ovf),       64'd0);
        check("rst_zero",      64'(zero),      64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_5_10",   32'd5,          32'd10, 1'b0);
        run_op("sub_10_5",   32'd10,         32'd5,  1'b1);
        run_op("sub_5_10",   32'd5,          32'd10, 1'b1);
        run_op("add_maxpos", 32'h7FFF_FFFF,  32'd1,  1'b0);
        run_op("sub_minneg", 32'h8000_0000,  32'd1,  1'b1);
        run_op("add_wrap",   32'hFFFF_FFFF,  32'd1,  1'b0);

        // Backpressure: hold the result for 5 cycles and poke in_valid meanwhile
        e = model(32'h1234_5678, 32'h0FED_CBA8, 1'b0);
        x = 32'h1234_5678; y = 32'h0FED_CBA8; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 40) begin
            @(posedge clk); #1; w++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 1 || i == 2);
            x = 32'hDEAD_BEEF; y = 32'h0000_0001; sub = 1'b1;
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready",  64'(in_ready),  64'd0);
            check("bp_s",         64'(s),         64'(e[31:0]));
            check("bp_cout",      64'(cout),      64'(e[32]));
            check("bp_ovf",       64'(ovf),       64'(e[33]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_after_rdy",  64'(in_ready),  64'd1);
        check("bp_after_ovld", 64'(out_valid), 64'd0);
        check("bp_s_held",     64'(s),         64'(e[31:0]));
        // The poked operands must not have started a hidden operation
        repeat (10) @(posedge clk);
        #1;
        check("bp_no_ghost", 64'(out_valid), 64'd0);

        // Reset in the middle of RUN
        x = 32'd100; y = 32'd200; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 64'(in_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_s",         64'(s),         64'd0);
        check("mid_rst_cout",      64'(cout),      64'd0);
        check("mid_rst_ovf",       64'(ovf),       64'd0);
        check("mid_rst_zero",      64'(zero),      64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("add_3_4", 32'd3, 32'd4, 1'b0);

        // Back-to-back random ops with both handshakes held high
        issued = 0; got = 0; cyc = 0; last = -1;
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < 20 && cyc < 600) begin
            if (in_ready) begin
                if (issued < 20) begin
                    ra = $urandom; rb = $urandom; rop = 1'($urandom_range(0, 1));
                    if (issued % 5 == 4) rb = ra;
                    x = ra; y = rb; sub = rop;
                    e = model(ra, rb, rop);
                    rq_s.push_back(e[31:0]);
                    rq_c.push_back(e[32]);
                    issued++;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                if (rq_s.size() > 0) begin
                    check("b2b_s",    64'(s),    64'(rq_s.pop_front()));
                    check("b2b_cout", 64'(cout), 64'(rq_c.pop_front()));
                end
                if (last >= 0) check("b2b_spacing", 64'(cyc - last), 64'd10);
                last = cyc;
                got++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_count",  64'(got),         64'd20);
        check("b2b_queued", 64'(rq_s.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
